pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Parametrised pipelined control unit for the 5-stage MIPS-subset core. It replaces the purely combinational decoder with three parts:
- a D-stage decoder;
- a registered D→E control pipeline register with stall/flush handling;
- a halt-drain state machine that stops fetch and waits for in-flight instructions to retire before asserting `halted`.

It adds ANDI/ORI/SLTI/BNE and illegal-opcode trapping.

## Interface
Parameters:
- DRAIN_STAGES, 3, cycles to wait after halt acceptance for E/M/W to retire (legal range 1–7)
- EXT_OPS, 1, 1 enables ANDI/ORI/SLTI/BNE decode; 0 treats them as illegal

Ports (clock and reset first):
- clk  in  1  single clock; all state is rising-edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- op  in  6  instrD[31:26]
- funct  in  6  instrD[5:0]
- validD  in  1  D holds a real instruction
- stallD  in  1  hazard unit holds D
- flushE  in  1  hazard unit bubbles E
- equalD  in  1  D-stage register compare result
- branchD  out  1  BEQ/BNE in D (combinational)
- pcsrcD  out  1  take branch (combinational)
- jumpD  out  1  J in D (combinational)
- stopfetchD  out  1  fetch must hold PC (combinational from state)
- regwriteE, memtoregE, memwriteE, regdstE, alusrcE, zeroextE  out  1 each  registered E controls
- alucontrolE  out  3  registered ALU op
- illegalE  out  1  registered one-cycle pulse: illegal op accepted
- illegal_seen  out  1  sticky illegal flag
- halted  out  1  drain complete

## Operation
- Decoded opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, HALT 111111.
- With EXT_OPS=1, also: ANDI 001100, ORI 001101, SLTI 001010, BNE 000101.
- ALU encoding: add 010, sub 110, and 000, or 001, slt 111.
  - LW/SW/ADDI → add.
  - BEQ/BNE → sub.
  - ANDI → and, ORI → or, SLTI → slt.
  - RTYPE by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Control field values:
  - zeroextE=1 only for ANDI/ORI.
  - regdst=1 only for RTYPE.
  - alusrc=1 for LW/SW/ADDI/ANDI/ORI/SLTI.
  - regwrite=1 for RTYPE/LW/ADDI/ANDI/ORI/SLTI.
  - memwrite=1 for SW; memtoreg=1 for LW.
- Illegal instruction: an undecoded op, or an RTYPE with undecoded funct. It is bubbled: all E controls 0, alucontrolE=010.
- Accept = validD & ~stallD & ~flushE & state==RUN.
- E register:
  - On accept, loads the decoded controls (bubble for HALT/J/illegal/branch writes per table above).
  - Otherwise it loads a bubble.
  - flushE has priority over everything except reset.
- Branches: pcsrcD = branchD & (BEQ ? equalD : ~equalD). branchD, pcsrcD and jumpD are forced 0 unless validD & state==RUN.
- Halt FSM: RUN → DRAIN → HALTED.
  - RUN → DRAIN: on accept of HALT; counter loads DRAIN_STAGES.
  - DRAIN: counter decrements each cycle. When counter==1, next state is HALTED.
  - HALTED: terminal; only reset exits it.
  - stopfetchD=1 in DRAIN and HALTED.
  - halted=1 only in HALTED.
- illegalE pulses on accept of an illegal instruction. illegal_seen sets on that pulse and clears only on reset.

## Timing
- Reset (async assert, immediate):
  - All E outputs 0, alucontrolE=010.
  - illegalE=0, illegal_seen=0, halted=0.
  - state=RUN, counter=0.
- Reset mid-DRAIN or in HALTED returns the FSM to RUN with no residual stopfetch.
- D-stage outputs are zero latency (combinational). E controls appear 1 cycle after accept.
- A stalled D instruction is re-decoded every cycle. Its E controls load on the first cycle with stallD=0 and flushE=0.
- Simultaneous stallD and flushE: E gets a bubble; D holds.
- Halt latency: HALT accepted in cycle N → stopfetchD=1 from cycle N+1 → halted=1 from cycle N+1+DRAIN_STAGES.
- Once the state is not RUN, instructions presented in D are ignored: no E update other than bubbles, no illegal pulse.
- The counter width is 3 bits and must not wrap. DRAIN_STAGES=1 goes DRAIN→HALTED after exactly one cycle.

## Test plan
- Reset:
  - Stimulus: assert reset asynchronously mid-cycle.
  - Required response: immediately alucontrolE=010, all other outputs 0. Release, then present ADD (op 0, funct 100000) → next cycle regwriteE=1, regdstE=1, alucontrolE=010.
- Extended ops:
  - Stimulus: ANDI (001100) with EXT_OPS=1.
  - Required response: alusrcE=1, zeroextE=1, alucontrolE=000, regwriteE=1.
  - Stimulus: the same op with EXT_OPS=0.
  - Required response: bubble, illegalE pulse, illegal_seen=1 held.
- Branches:
  - BNE with equalD=0 → pcsrcD=1.
  - BNE with equalD=1 → pcsrcD=0.
  - BEQ with equalD=1 → pcsrcD=1.
  - In all cases the E controls are a bubble.
- Stall/flush:
  - Stimulus: LW held 2 cycles with stallD=1, then released.
  - Required response: E bubbles for 2 cycles, then memtoregE=1.
  - Stimulus: stallD=1 and flushE=1 together.
  - Required response: bubble.
- Halt drain (DRAIN_STAGES=3):
  - Stimulus: HALT accepted at cycle 10.
  - Required response: stopfetchD=1 from cycle 11, halted=1 at cycle 14. A subsequent SW in D produces no memwriteE.
- Reset mid-drain:
  - Stimulus: reset at cycle 12 of the above.
  - Required response: stopfetchD=0 and halted=0 immediately; a new ADDI decodes normally.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// D-stage inputs and D/E-stage control outputs of the pipelined control unit.
// The core (master) drives the decode inputs; the control unit (slave) returns controls.
interface pipe_ctrl_unit_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       validD;
   logic       stallD;
   logic       flushE;
   logic       equalD;
   logic       branchD;
   logic       pcsrcD;
   logic       jumpD;
   logic       stopfetchD;
   logic       regwriteE;
   logic       memtoregE;
   logic       memwriteE;
   logic       regdstE;
   logic       alusrcE;
   logic       zeroextE;
   logic [2:0] alucontrolE;
   logic       illegalE;
   logic       illegal_seen;
   logic       halted;

   modport master (
      output op, funct, validD, stallD, flushE, equalD,
      input  branchD, pcsrcD, jumpD, stopfetchD,
      input  regwriteE, memtoregE, memwriteE, regdstE, alusrcE, zeroextE,
      input  alucontrolE, illegalE, illegal_seen, halted
   );

   modport slave (
      input  op, funct, validD, stallD, flushE, equalD,
      output branchD, pcsrcD, jumpD, stopfetchD,
      output regwriteE, memtoregE, memwriteE, regdstE, alusrcE, zeroextE,
      output alucontrolE, illegalE, illegal_seen, halted
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS-subset control: D-stage decoder, D->E control register with
// stall/flush bubbling, and a halt FSM that drains E/M/W before reporting halted.
module pipe_ctrl_unit #(
   parameter int DRAIN_STAGES = 3,
   parameter bit EXT_OPS      = 1'b1
) (
   input logic             clk,
   input logic             reset,
   pipe_ctrl_unit_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} haltState_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   haltState_t state, stateNext;
   logic [2:0] drainCount, drainCountNext;

   logic       decRegWrite, decMemToReg, decMemWrite, decRegDst, decAluSrc, decZeroExt;
   logic       decIllegal, decBranch, decBne, decJump, decHalt;
   logic [2:0] decAluControl;
   logic       accept, loadCtrl, runD;

   always_comb begin
      decRegWrite   = 1'b0;
      decMemToReg   = 1'b0;
      decMemWrite   = 1'b0;
      decRegDst     = 1'b0;
      decAluSrc     = 1'b0;
      decZeroExt    = 1'b0;
      decIllegal    = 1'b0;
      decBranch     = 1'b0;
      decBne        = 1'b0;
      decJump       = 1'b0;
      decHalt       = 1'b0;
      decAluControl = ALU_ADD;
      case (bus.op)
         6'b000000: begin
            decRegWrite = 1'b1;
            decRegDst   = 1'b1;
            case (bus.funct)
               6'b100000: decAluControl = ALU_ADD;
               6'b100010: decAluControl = ALU_SUB;
               6'b100100: decAluControl = ALU_AND;
               6'b100101: decAluControl = ALU_OR;
               6'b101010: decAluControl = ALU_SLT;
               default:   decIllegal    = 1'b1;
            endcase
         end
         6'b100011: begin decRegWrite = 1'b1; decAluSrc = 1'b1; decMemToReg = 1'b1; end
         6'b101011: begin decAluSrc = 1'b1; decMemWrite = 1'b1; end
         6'b000100: begin decBranch = 1'b1; decAluControl = ALU_SUB; end
         6'b001000: begin decRegWrite = 1'b1; decAluSrc = 1'b1; end
         6'b000010: decJump = 1'b1;
         6'b111111: decHalt = 1'b1;
         6'b001100: begin
            if (EXT_OPS) begin
               decRegWrite = 1'b1; decAluSrc = 1'b1; decZeroExt = 1'b1; decAluControl = ALU_AND;
            end else decIllegal = 1'b1;
         end
         6'b001101: begin
            if (EXT_OPS) begin
               decRegWrite = 1'b1; decAluSrc = 1'b1; decZeroExt = 1'b1; decAluControl = ALU_OR;
            end else decIllegal = 1'b1;
         end
         6'b001010: begin
            if (EXT_OPS) begin
               decRegWrite = 1'b1; decAluSrc = 1'b1; decAluControl = ALU_SLT;
            end else decIllegal = 1'b1;
         end
         6'b000101: begin
            if (EXT_OPS) begin
               decBranch = 1'b1; decBne = 1'b1; decAluControl = ALU_SUB;
            end else decIllegal = 1'b1;
         end
         default: decIllegal = 1'b1;
      endcase
   end

   // flushE and stallD both suppress accept, so flush wins without a separate path.
   assign accept   = bus.validD & ~bus.stallD & ~bus.flushE & (state == RUN);
   assign loadCtrl = accept & ~(decIllegal | decBranch | decJump | decHalt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.regwriteE    <= 1'b0;
         bus.memtoregE    <= 1'b0;
         bus.memwriteE    <= 1'b0;
         bus.regdstE      <= 1'b0;
         bus.alusrcE      <= 1'b0;
         bus.zeroextE     <= 1'b0;
         bus.alucontrolE  <= ALU_ADD;
         bus.illegalE     <= 1'b0;
         bus.illegal_seen <= 1'b0;
      end else begin
         bus.regwriteE   <= loadCtrl & decRegWrite;
         bus.memtoregE   <= loadCtrl & decMemToReg;
         bus.memwriteE   <= loadCtrl & decMemWrite;
         bus.regdstE     <= loadCtrl & decRegDst;
         bus.alusrcE     <= loadCtrl & decAluSrc;
         bus.zeroextE    <= loadCtrl & decZeroExt;
         bus.alucontrolE <= loadCtrl ? decAluControl : ALU_ADD;
         bus.illegalE    <= accept & decIllegal;
         if (accept & decIllegal)
            bus.illegal_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         drainCount <= 3'd0;
      end else begin
         state      <= stateNext;
         drainCount <= drainCountNext;
      end
   end

   // The counter leaves DRAIN at 1, so it bottoms out at 0 and never wraps.
   always_comb begin
      stateNext      = state;
      drainCountNext = drainCount;
      case (state)
         RUN: begin
            if (accept & decHalt) begin
               stateNext      = DRAIN;
               drainCountNext = 3'(DRAIN_STAGES);
            end
         end
         DRAIN: begin
            drainCountNext = drainCount - 3'd1;
            if (drainCount == 3'd1)
               stateNext = HALTED;
         end
         HALTED:  stateNext = HALTED;
         default: stateNext = RUN;
      endcase
   end

   always_comb begin
      runD           = bus.validD & (state == RUN);
      bus.branchD    = runD & decBranch;
      bus.pcsrcD     = runD & decBranch & (decBne ? ~bus.equalD : bus.equalD);
      bus.jumpD      = runD & decJump;
      bus.stopfetchD = (state != RUN);
      bus.halted     = (state == HALTED);
   end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed and randomized checks of pipe_ctrl_unit (EXT_OPS=1 and EXT_OPS=0 side by side)
// against an opcode-table reference model and a cycle-age model of the halt drain.
module tb_pipe_ctrl_unit;
   localparam int DRAIN = 3;
   localparam logic [8:0] BUBBLE = 9'b000000_010;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_unit_if busA ();
   pipe_ctrl_unit_if busB ();

   pipe_ctrl_unit #(.DRAIN_STAGES(DRAIN), .EXT_OPS(1'b1)) dutExt  (.clk(clk), .reset(reset), .bus(busA));
   pipe_ctrl_unit #(.DRAIN_STAGES(DRAIN), .EXT_OPS(1'b0)) dutBase (.clk(clk), .reset(reset), .bus(busB));

   logic [8:0] obsE [2];
   logic [8:0] obsD [2];
   logic [8:0] obsS [2];
   assign obsE[0] = {busA.regwriteE, busA.memtoregE, busA.memwriteE, busA.regdstE,
                     busA.alusrcE, busA.zeroextE, busA.alucontrolE};
   assign obsE[1] = {busB.regwriteE, busB.memtoregE, busB.memwriteE, busB.regdstE,
                     busB.alusrcE, busB.zeroextE, busB.alucontrolE};
   assign obsD[0] = {5'd0, busA.branchD, busA.pcsrcD, busA.jumpD, busA.stopfetchD};
   assign obsD[1] = {5'd0, busB.branchD, busB.pcsrcD, busB.jumpD, busB.stopfetchD};
   assign obsS[0] = {5'd0, busA.illegalE, busA.illegal_seen, busA.halted, busA.stopfetchD};
   assign obsS[1] = {5'd0, busB.illegalE, busB.illegal_seen, busB.halted, busB.stopfetchD};

   int compared = 0;
   int mismatched = 0;
   int haltAge = -1;          // edges since HALT was accepted; -1 while running
   bit sticky [2] = '{1'b0, 1'b0};

   typedef struct packed {
      logic rw, mtr, mw, rd, as, ze;
      logic [2:0] alu;
      logic ill, br, bne, jmp, hlt;
   } ctl_t;

   function automatic ctl_t decodeRef(input logic [5:0] o, input logic [5:0] f, input bit ext);
      ctl_t c;
      c = '0;
      c.alu = 3'b010;
      case (o)
         6'b000000: begin
            c.rw = 1; c.rd = 1;
            if      (f == 6'b100000) c.alu = 3'b010;
            else if (f == 6'b100010) c.alu = 3'b110;
            else if (f == 6'b100100) c.alu = 3'b000;
            else if (f == 6'b100101) c.alu = 3'b001;
            else if (f == 6'b101010) c.alu = 3'b111;
            else c.ill = 1;
         end
         6'b100011: begin c.rw = 1; c.as = 1; c.mtr = 1; end
         6'b101011: begin c.as = 1; c.mw = 1; end
         6'b000100: c.br = 1;
         6'b001000: begin c.rw = 1; c.as = 1; end
         6'b000010: c.jmp = 1;
         6'b111111: c.hlt = 1;
         6'b001100: if (ext) begin c.rw = 1; c.as = 1; c.ze = 1; c.alu = 3'b000; end else c.ill = 1;
         6'b001101: if (ext) begin c.rw = 1; c.as = 1; c.ze = 1; c.alu = 3'b001; end else c.ill = 1;
         6'b001010: if (ext) begin c.rw = 1; c.as = 1; c.alu = 3'b111; end else c.ill = 1;
         6'b000101: if (ext) begin c.br = 1; c.bne = 1; end else c.ill = 1;
         default:   c.ill = 1;
      endcase
      return c;
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic v, s, fl, e);
      busA.op = o; busA.funct = f; busA.validD = v; busA.stallD = s; busA.flushE = fl; busA.equalD = e;
      busB.op = o; busB.funct = f; busB.validD = v; busB.stallD = s; busB.flushE = fl; busB.equalD = e;
   endtask

   // One clock: check D outputs combinationally, then E/status outputs after the edge.
   task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic v, s, fl, e);
      ctl_t d;
      logic run, acc, taken, haltNext;
      logic [8:0] expE [2];
      logic illNext [2];
      haltNext = 1'b0;
      drive(o, f, v, s, fl, e);
      #1;
      run = (haltAge < 0);
      for (int i = 0; i < 2; i++) begin
         d = decodeRef(o, f, i == 0);
         taken = d.bne ? ~e : e;
         check($sformatf("%s/D%0d", tag, i), obsD[i],
               {5'd0, v & run & d.br, v & run & d.br & taken, v & run & d.jmp, ~run});
         acc = v & ~s & ~fl & run;
         expE[i] = (acc & ~(d.ill | d.br | d.jmp | d.hlt)) ?
                   {d.rw, d.mtr, d.mw, d.rd, d.as, d.ze, d.alu} : BUBBLE;
         illNext[i] = acc & d.ill;
         if (acc & d.hlt) haltNext = 1'b1;
      end
      @(posedge clk);
      #1;
      if (haltAge >= 0) haltAge++;
      if (haltNext) haltAge = 0;
      for (int i = 0; i < 2; i++) begin
         if (illNext[i]) sticky[i] = 1'b1;
         check($sformatf("%s/E%0d", tag, i), obsE[i], expE[i]);
         check($sformatf("%s/S%0d", tag, i), obsS[i],
               {5'd0, illNext[i], sticky[i], haltAge >= DRAIN, haltAge >= 0});
      end
   endtask

   // Asynchronous reset asserted and released away from the clock edges.
   task automatic asyncReset(input string tag);
      drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      haltAge = -1;
      for (int i = 0; i < 2; i++) begin
         sticky[i] = 1'b0;
         check($sformatf("%s/rstE%0d", tag, i), obsE[i], BUBBLE);
         check($sformatf("%s/rstS%0d", tag, i), obsS[i], 9'd0);
         check($sformatf("%s/rstD%0d", tag, i), obsD[i], 9'd0);
      end
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   logic [5:0] opList [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                               6'b000010, 6'b001100, 6'b001101, 6'b001010, 6'b000101};
   logic [5:0] fnList [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   initial begin
      logic [5:0] ro, rf;
      drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      asyncReset("reset");
      step("add", 6'b000000, 6'b100000, 1, 0, 0, 0);
      step("andi", 6'b001100, 6'd0, 1, 0, 0, 0);
      step("idle1", 6'd0, 6'd0, 0, 0, 0, 0);
      step("bne_ne", 6'b000101, 6'd0, 1, 0, 0, 0);
      step("bne_eq", 6'b000101, 6'd0, 1, 0, 0, 1);
      step("beq_eq", 6'b000100, 6'd0, 1, 0, 0, 1);
      step("beq_ne", 6'b000100, 6'd0, 1, 0, 0, 0);
      step("lw_stall1", 6'b100011, 6'd0, 1, 1, 0, 0);
      step("lw_stall2", 6'b100011, 6'd0, 1, 1, 0, 0);
      step("lw_go", 6'b100011, 6'd0, 1, 0, 0, 0);
      step("stall_flush", 6'b100011, 6'd0, 1, 1, 1, 0);
      step("flush", 6'b001000, 6'd0, 1, 0, 1, 0);
      step("rtype_bad", 6'b000000, 6'b111000, 1, 0, 0, 0);
      step("bad_op", 6'b110000, 6'd0, 1, 0, 0, 0);

      for (int n = 0; n < 150; n++) begin
         ro = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 62)) : opList[$urandom_range(0, 9)];
         rf = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fnList[$urandom_range(0, 4)];
         step("rand", ro, rf, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      end

      asyncReset("reset2");
      step("halt", 6'b111111, 6'd0, 1, 0, 0, 0);
      step("sw_drain", 6'b101011, 6'd0, 1, 0, 0, 0);
      step("bad_drain", 6'b110000, 6'd0, 1, 0, 0, 0);
      step("beq_drain", 6'b000100, 6'd0, 1, 0, 0, 1);
      step("sw_halted", 6'b101011, 6'd0, 1, 0, 0, 0);
      step("j_halted", 6'b000010, 6'd0, 1, 0, 0, 0);

      asyncReset("reset3");
      step("halt2", 6'b111111, 6'd0, 1, 0, 0, 0);
      step("drain2a", 6'b101011, 6'd0, 1, 0, 0, 0);
      asyncReset("reset_mid_drain");
      step("addi", 6'b001000, 6'd0, 1, 0, 0, 0);
      step("j", 6'b000010, 6'd0, 1, 0, 0, 0);
      step("ori", 6'b001101, 6'd0, 1, 0, 0, 0);
      step("slti", 6'b001010, 6'd0, 1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
